// File: rtl/i2c_slave_pkg.sv
// Shared widths and idle byte values for the behavioural I2C slave storage block.
package i2c_slave_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_DATA_W = 8;

    typedef logic [I2C_DATA_W-1:0] i2c_byte_t;
    typedef logic [I2C_ADDR_W-1:0] i2c_addr_t;

    localparam i2c_byte_t TX_EMPTY_BYTE = 8'hFF;
    localparam i2c_byte_t RX_EMPTY_BYTE = 8'h00;

endpackage

// File: rtl/i2c_slave_intf_if.sv
// Host/engine-facing signal bundle of the I2C slave storage block.
interface i2c_slave_intf_if
    import i2c_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 256
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          addr_wr_en;
    i2c_addr_t     addr_wr_data;
    i2c_addr_t     i2c_slave_addr;

    logic          rx_wr_en;
    i2c_byte_t     rx_wr_data;
    logic          rx_rd_en;
    i2c_byte_t     rx_rd_data;
    logic [AW:0]   rx_count;
    logic          rx_empty;
    logic          rx_full;
    logic          rx_overflow;
    logic          rx_flush;

    logic          tx_wr_en;
    i2c_byte_t     tx_wr_data;
    logic          tx_rd_en;
    i2c_byte_t     tx_rd_data;
    logic [AW:0]   tx_count;
    logic          tx_empty;
    logic          tx_full;
    logic          tx_underflow;
    logic          tx_flush;

    modport slave (
        input  addr_wr_en, addr_wr_data,
        output i2c_slave_addr,
        input  rx_wr_en, rx_wr_data, rx_rd_en, rx_flush,
        output rx_rd_data, rx_count, rx_empty, rx_full, rx_overflow,
        input  tx_wr_en, tx_wr_data, tx_rd_en, tx_flush,
        output tx_rd_data, tx_count, tx_empty, tx_full, tx_underflow
    );

    modport master (
        output addr_wr_en, addr_wr_data,
        input  i2c_slave_addr,
        output rx_wr_en, rx_wr_data, rx_rd_en, rx_flush,
        input  rx_rd_data, rx_count, rx_empty, rx_full, rx_overflow,
        output tx_wr_en, tx_wr_data, tx_rd_en, tx_flush,
        input  tx_rd_data, tx_count, tx_empty, tx_full, tx_underflow
    );

endinterface

// File: rtl/i2c_byte_fifo.sv
// Circular byte FIFO with first-word fall-through read, occupancy count, flush and
// one sticky error flag (overflow or underflow, chosen by StickyOnOverflow).
module i2c_byte_fifo
    import i2c_slave_pkg::*;
#(
    parameter int unsigned Depth            = 256,
    parameter i2c_byte_t   EmptyByte        = RX_EMPTY_BYTE,
    parameter bit          StickyOnOverflow = 1'b1,
    localparam int unsigned AW              = $clog2(Depth)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        wr_en_i,
    input  i2c_byte_t   wr_data_i,
    input  logic        rd_en_i,
    output i2c_byte_t   rd_data_o,
    output logic [AW:0] count_o,
    output logic        empty_o,
    output logic        full_o,
    output logic        sticky_o
);

    localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          sticky_q, sticky_d;
    i2c_byte_t     mem_q [Depth];

    logic empty, full, rd_ok, wr_ok, err_event;

    assign empty = (count_q == '0);
    assign full  = (count_q == DepthCnt);
    assign rd_ok = rd_en_i & ~empty;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign wr_ok = wr_en_i & (~full | rd_ok);
    assign err_event = StickyOnOverflow ? (wr_en_i & ~wr_ok) : (rd_en_i & empty);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sticky_d = sticky_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            sticky_d = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
            sticky_d = sticky_q | err_event;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = empty ? EmptyByte : mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = empty;
    assign full_o    = full;
    assign sticky_o  = sticky_q;

endmodule

// File: rtl/i2c_slave_intf.sv
// I2C slave storage block: programmable slave address plus RX and TX byte FIFOs.
module i2c_slave_intf
    import i2c_slave_pkg::*;
#(
    parameter int unsigned G_SLAVE_I2C_FIFO_DEPTH = 256,
    parameter i2c_addr_t   G_DEFAULT_SLAVE_ADDR   = 7'h50
) (
    input logic            clk,
    input logic            rst_n,
    i2c_slave_intf_if.slave bus
);

    i2c_addr_t addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (bus.addr_wr_en) addr_d = bus.addr_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_q <= G_DEFAULT_SLAVE_ADDR;
        else        addr_q <= addr_d;
    end

    assign bus.i2c_slave_addr = addr_q;

    i2c_byte_fifo #(
        .Depth            (G_SLAVE_I2C_FIFO_DEPTH),
        .EmptyByte        (RX_EMPTY_BYTE),
        .StickyOnOverflow (1'b1)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (bus.rx_flush),
        .wr_en_i   (bus.rx_wr_en),
        .wr_data_i (bus.rx_wr_data),
        .rd_en_i   (bus.rx_rd_en),
        .rd_data_o (bus.rx_rd_data),
        .count_o   (bus.rx_count),
        .empty_o   (bus.rx_empty),
        .full_o    (bus.rx_full),
        .sticky_o  (bus.rx_overflow)
    );

    // TX idles at 8'hFF so an empty pop looks like a released bus.
    i2c_byte_fifo #(
        .Depth            (G_SLAVE_I2C_FIFO_DEPTH),
        .EmptyByte        (TX_EMPTY_BYTE),
        .StickyOnOverflow (1'b0)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (bus.tx_flush),
        .wr_en_i   (bus.tx_wr_en),
        .wr_data_i (bus.tx_wr_data),
        .rd_en_i   (bus.tx_rd_en),
        .rd_data_o (bus.tx_rd_data),
        .count_o   (bus.tx_count),
        .empty_o   (bus.tx_empty),
        .full_o    (bus.tx_full),
        .sticky_o  (bus.tx_underflow)
    );

endmodule

// File: tb/tb_i2c_slave_intf.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_i2c_slave_intf;
    import i2c_slave_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         m_ovf;
    bit         m_udf;
    logic [6:0] m_addr;

    i2c_slave_intf_if #(.DEPTH(DEPTH)) bus ();

    i2c_slave_intf #(
        .G_SLAVE_I2C_FIFO_DEPTH (DEPTH),
        .G_DEFAULT_SLAVE_ADDR   (7'h50)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.addr_wr_en = 1'b0;
        bus.rx_wr_en   = 1'b0;
        bus.rx_rd_en   = 1'b0;
        bus.rx_flush   = 1'b0;
        bus.tx_wr_en   = 1'b0;
        bus.tx_rd_en   = 1'b0;
        bus.tx_flush   = 1'b0;
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_addr = 7'h50;
    endtask

    // Applies one clock of host/engine activity to the queue model.
    task automatic model_step();
        bit rd_ok;
        bit wr_ok;
        if (bus.rx_flush) begin
            rxq.delete();
            m_ovf = 1'b0;
        end else begin
            rd_ok = bus.rx_rd_en && (rxq.size() > 0);
            wr_ok = bus.rx_wr_en && ((rxq.size() < DEPTH) || rd_ok);
            if (bus.rx_wr_en && !wr_ok) m_ovf = 1'b1;
            if (rd_ok) void'(rxq.pop_front());
            if (wr_ok) rxq.push_back(bus.rx_wr_data);
        end
        if (bus.tx_flush) begin
            txq.delete();
            m_udf = 1'b0;
        end else begin
            rd_ok = bus.tx_rd_en && (txq.size() > 0);
            wr_ok = bus.tx_wr_en && ((txq.size() < DEPTH) || rd_ok);
            if (bus.tx_rd_en && (txq.size() == 0)) m_udf = 1'b1;
            if (rd_ok) void'(txq.pop_front());
            if (wr_ok) txq.push_back(bus.tx_wr_data);
        end
        if (bus.addr_wr_en) m_addr = bus.addr_wr_data;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.addr_wr_data = '0;
        bus.rx_wr_data   = '0;
        bus.tx_wr_data   = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (bus.i2c_slave_addr !== 7'h50) begin
            n_errors++; $display("FAIL reset_addr got %h exp 50", bus.i2c_slave_addr);
        end
        n_checks++;
        if (bus.rx_empty !== 1'b1 || bus.tx_empty !== 1'b1) begin
            n_errors++; $display("FAIL reset_empty got rx=%b tx=%b exp 1 1", bus.rx_empty, bus.tx_empty);
        end
        n_checks++;
        if (bus.rx_full !== 1'b0 || bus.tx_full !== 1'b0) begin
            n_errors++; $display("FAIL reset_full got rx=%b tx=%b exp 0 0", bus.rx_full, bus.tx_full);
        end
        n_checks++;
        if (bus.rx_count !== 3'd0 || bus.tx_count !== 3'd0) begin
            n_errors++; $display("FAIL reset_count got rx=%0d tx=%0d exp 0 0", bus.rx_count, bus.tx_count);
        end
        n_checks++;
        if (bus.rx_overflow !== 1'b0 || bus.tx_underflow !== 1'b0) begin
            n_errors++; $display("FAIL reset_sticky got ovf=%b udf=%b exp 0 0", bus.rx_overflow, bus.tx_underflow);
        end
    endtask

    task automatic test_addr();
        bus.addr_wr_en = 1'b1; bus.addr_wr_data = 7'h2A;
        tick();
        n_checks++;
        if (bus.i2c_slave_addr !== 7'h2A) begin
            n_errors++; $display("FAIL addr_load got %h exp 2a", bus.i2c_slave_addr);
        end
        bus.rx_wr_en = 1'b1; bus.rx_wr_data = 8'h77;
        tick();
        // Asynchronous reset between edges: no clock is allowed to intervene.
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.i2c_slave_addr !== 7'h50) begin
            n_errors++; $display("FAIL addr_async_rst got %h exp 50", bus.i2c_slave_addr);
        end
        n_checks++;
        if (bus.rx_count !== 3'd0 || bus.rx_empty !== 1'b1) begin
            n_errors++; $display("FAIL rx_async_discard got cnt=%0d empty=%b exp 0 1", bus.rx_count, bus.rx_empty);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_rx_order();
        logic [7:0] seq [3];
        seq[0] = 8'hA5; seq[1] = 8'h3C; seq[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            bus.rx_wr_en = 1'b1; bus.rx_wr_data = seq[i];
            tick();
        end
        n_checks++;
        if (bus.rx_count !== 3'd3 || bus.rx_rd_data !== 8'hA5) begin
            n_errors++; $display("FAIL rx_fill got cnt=%0d head=%h exp 3 a5", bus.rx_count, bus.rx_rd_data);
        end
        for (int i = 0; i < 3; i++) begin
            bus.rx_rd_en = 1'b1;
            #1;
            n_checks++;
            if (bus.rx_rd_data !== seq[i]) begin
                n_errors++; $display("FAIL rx_pop%0d got %h exp %h", i, bus.rx_rd_data, seq[i]);
            end
            tick();
        end
        n_checks++;
        if (bus.rx_empty !== 1'b1 || bus.rx_rd_data !== RX_EMPTY_BYTE) begin
            n_errors++; $display("FAIL rx_drained got empty=%b data=%h exp 1 00", bus.rx_empty, bus.rx_rd_data);
        end
    endtask

    task automatic test_tx_wrap();
        for (int i = 1; i <= 4; i++) begin
            bus.tx_wr_en = 1'b1; bus.tx_wr_data = 8'(i);
            tick();
        end
        n_checks++;
        if (bus.tx_full !== 1'b1) begin
            n_errors++; $display("FAIL tx_full got %b exp 1", bus.tx_full);
        end
        bus.tx_wr_en = 1'b1; bus.tx_wr_data = 8'h05;
        tick();
        n_checks++;
        if (bus.tx_count !== 3'd4 || bus.tx_rd_data !== 8'h01) begin
            n_errors++; $display("FAIL tx_drop got cnt=%0d head=%h exp 4 01", bus.tx_count, bus.tx_rd_data);
        end
        for (int i = 1; i <= 2; i++) begin
            n_checks++;
            if (bus.tx_rd_data !== 8'(i)) begin
                n_errors++; $display("FAIL tx_pop_a got %h exp %h", bus.tx_rd_data, 8'(i));
            end
            bus.tx_rd_en = 1'b1;
            tick();
        end
        for (int i = 5; i <= 6; i++) begin
            bus.tx_wr_en = 1'b1; bus.tx_wr_data = 8'(i);
            tick();
        end
        for (int i = 3; i <= 6; i++) begin
            n_checks++;
            if (bus.tx_rd_data !== 8'(i)) begin
                n_errors++; $display("FAIL tx_pop_wrap got %h exp %h", bus.tx_rd_data, 8'(i));
            end
            bus.tx_rd_en = 1'b1;
            tick();
        end
        n_checks++;
        if (bus.tx_empty !== 1'b1 || bus.tx_count !== 3'd0) begin
            n_errors++; $display("FAIL tx_wrap_end got empty=%b cnt=%0d exp 1 0", bus.tx_empty, bus.tx_count);
        end
    endtask

    task automatic test_tx_underflow();
        bus.tx_rd_en = 1'b1;
        #1;
        n_checks++;
        if (bus.tx_rd_data !== TX_EMPTY_BYTE) begin
            n_errors++; $display("FAIL tx_idle_byte got %h exp ff", bus.tx_rd_data);
        end
        tick();
        n_checks++;
        if (bus.tx_underflow !== 1'b1 || bus.tx_count !== 3'd0) begin
            n_errors++; $display("FAIL tx_underflow got udf=%b cnt=%0d exp 1 0", bus.tx_underflow, bus.tx_count);
        end
        bus.tx_flush = 1'b1;
        tick();
        n_checks++;
        if (bus.tx_underflow !== 1'b0) begin
            n_errors++; $display("FAIL tx_flush_udf got %b exp 0", bus.tx_underflow);
        end
    endtask

    task automatic test_simultaneous();
        bus.rx_flush = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            bus.rx_wr_en = 1'b1; bus.rx_wr_data = 8'(i * 8'h11);
            tick();
        end
        bus.rx_wr_en = 1'b1; bus.rx_wr_data = 8'h09; bus.rx_rd_en = 1'b1;
        tick();
        n_checks++;
        if (bus.rx_count !== 3'd4 || bus.rx_rd_data !== 8'h22 || bus.rx_overflow !== 1'b0) begin
            n_errors++; $display("FAIL rx_full_rw got cnt=%0d head=%h ovf=%b exp 4 22 0",
                                 bus.rx_count, bus.rx_rd_data, bus.rx_overflow);
        end
        bus.rx_wr_en = 1'b1; bus.rx_wr_data = 8'h55;
        tick();
        n_checks++;
        if (bus.rx_overflow !== 1'b1 || bus.rx_count !== 3'd4) begin
            n_errors++; $display("FAIL rx_overflow got ovf=%b cnt=%0d exp 1 4", bus.rx_overflow, bus.rx_count);
        end
        // Flush wins over a concurrent push.
        bus.rx_flush = 1'b1; bus.rx_wr_en = 1'b1; bus.rx_wr_data = 8'h66;
        tick();
        n_checks++;
        if (bus.rx_overflow !== 1'b0 || bus.rx_count !== 3'd0) begin
            n_errors++; $display("FAIL rx_flush got ovf=%b cnt=%0d exp 0 0", bus.rx_overflow, bus.rx_count);
        end
        bus.rx_wr_en = 1'b1; bus.rx_wr_data = 8'h07; bus.rx_rd_en = 1'b1;
        tick();
        n_checks++;
        if (bus.rx_count !== 3'd1 || bus.rx_rd_data !== 8'h07) begin
            n_errors++; $display("FAIL rx_empty_rw got cnt=%0d head=%h exp 1 07", bus.rx_count, bus.rx_rd_data);
        end
        bus.tx_wr_en = 1'b1; bus.tx_wr_data = 8'h3E; bus.tx_rd_en = 1'b1;
        tick();
        n_checks++;
        if (bus.tx_count !== 3'd1 || bus.tx_rd_data !== 8'h3E || bus.tx_underflow !== 1'b1) begin
            n_errors++; $display("FAIL tx_empty_rw got cnt=%0d head=%h udf=%b exp 1 3e 1",
                                 bus.tx_count, bus.tx_rd_data, bus.tx_underflow);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_rx;
        logic [7:0] exp_tx;
        for (int n = 0; n < 400; n++) begin
            exp_rx = (rxq.size() > 0) ? rxq[0] : 8'h00;
            exp_tx = (txq.size() > 0) ? txq[0] : 8'hFF;
            n_checks++;
            if (int'(bus.rx_count) != rxq.size() || bus.rx_rd_data !== exp_rx) begin
                n_errors++; $display("FAIL rnd_rx@%0d got cnt=%0d head=%h exp %0d %h",
                                     n, bus.rx_count, bus.rx_rd_data, rxq.size(), exp_rx);
            end
            n_checks++;
            if (bus.rx_empty !== (rxq.size() == 0) || bus.rx_full !== (rxq.size() == DEPTH)
                || bus.rx_overflow !== m_ovf) begin
                n_errors++; $display("FAIL rnd_rx_flags@%0d got e=%b f=%b o=%b exp size=%0d o=%b",
                                     n, bus.rx_empty, bus.rx_full, bus.rx_overflow, rxq.size(), m_ovf);
            end
            n_checks++;
            if (int'(bus.tx_count) != txq.size() || bus.tx_rd_data !== exp_tx) begin
                n_errors++; $display("FAIL rnd_tx@%0d got cnt=%0d head=%h exp %0d %h",
                                     n, bus.tx_count, bus.tx_rd_data, txq.size(), exp_tx);
            end
            n_checks++;
            if (bus.tx_empty !== (txq.size() == 0) || bus.tx_full !== (txq.size() == DEPTH)
                || bus.tx_underflow !== m_udf) begin
                n_errors++; $display("FAIL rnd_tx_flags@%0d got e=%b f=%b u=%b exp size=%0d u=%b",
                                     n, bus.tx_empty, bus.tx_full, bus.tx_underflow, txq.size(), m_udf);
            end
            n_checks++;
            if (bus.i2c_slave_addr !== m_addr) begin
                n_errors++; $display("FAIL rnd_addr@%0d got %h exp %h", n, bus.i2c_slave_addr, m_addr);
            end
            bus.rx_wr_en     = ($urandom_range(99) < 50);
            bus.rx_rd_en     = ($urandom_range(99) < 45);
            bus.rx_flush     = ($urandom_range(99) < 3);
            bus.rx_wr_data   = 8'($urandom);
            bus.tx_wr_en     = ($urandom_range(99) < 45);
            bus.tx_rd_en     = ($urandom_range(99) < 50);
            bus.tx_flush     = ($urandom_range(99) < 3);
            bus.tx_wr_data   = 8'($urandom);
            bus.addr_wr_en   = ($urandom_range(99) < 5);
            bus.addr_wr_data = 7'($urandom);
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_addr();
        test_rx_order();
        test_tx_wrap();
        test_tx_underflow();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_intf.md
Name: i2c_slave_intf

Overview:
Storage and configuration block for the behavioural I2C slave model. It holds the 7-bit slave address, an RX FIFO and a TX FIFO. The I2C slave engine writes received bytes into the RX FIFO and pulls bytes to transmit from the TX FIFO. The testbench host reads RX bytes, preloads TX bytes and programs the slave address.

Parameters:
G_SLAVE_I2C_FIFO_DEPTH, 256, entries per FIFO. Must be a power of 2 and at least 2. AW = $clog2(depth).
G_DEFAULT_SLAVE_ADDR, 7'h50, slave address loaded at reset.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
addr_wr_en  in  1  host strobe: load a new slave address.
addr_wr_data  in  7  new slave address.
i2c_slave_addr  out  7  current slave address.
rx_wr_en  in  1  engine strobe: push a received byte.
rx_wr_data  in  8  received byte.
rx_rd_en  in  1  host strobe: pop an RX byte.
rx_rd_data  out  8  RX head byte, first-word fall-through.
rx_count  out  AW+1  RX occupancy.
rx_empty, rx_full  out  1 each  RX status flags.
rx_overflow  out  1  sticky: a push was attempted while RX was full.
tx_wr_en  in  1  host strobe: push a byte to transmit.
tx_wr_data  in  8  byte to transmit.
tx_rd_en  in  1  engine strobe: pop a TX byte.
tx_rd_data  out  8  TX head byte, first-word fall-through.
tx_count  out  AW+1  TX occupancy.
tx_empty, tx_full  out  1 each  TX status flags.
tx_underflow  out  1  sticky: a pop was attempted while TX was empty.
rx_flush, tx_flush  in  1 each  synchronous clear of the corresponding FIFO.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all pointers and counts = 0; empty = 1; full = 0;
  - overflow and underflow flags = 0;
  - i2c_slave_addr = G_DEFAULT_SLAVE_ADDR.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all queued data immediately.
- Each FIFO is a circular buffer with AW-bit pointers (ptr_write, ptr_read).
  - Pointers wrap from depth-1 to 0.
  - Count is tracked separately in AW+1 bits.
  - full = (count == depth); empty = (count == 0).
- Write: when wr_en and not full, mem[ptr_write] <= data, ptr_write++, count++.
  - Write while full (and no simultaneous read): data dropped, pointer unchanged.
  - RX only: rx_overflow set; it stays set until reset or rx_flush.
- Read: rd_data = mem[ptr_read] combinationally, so there is zero latency and the byte is valid while rd_en is asserted.
  - When rd_en and not empty: ptr_read++, count-- at the clock edge.
- Read while empty:
  - pointer and count unchanged;
  - rx_rd_data = 8'h00;
  - tx_rd_data = 8'hFF (idle bus level);
  - TX only: tx_underflow set, sticky until reset or tx_flush.
- Simultaneous read and write, same cycle:
  - not empty and not full: both occur; count unchanged.
  - full: both occur; count stays at depth; no overflow.
  - empty: write occurs; read is rejected and counts as an empty read (underflow applies on TX); no bypass of the written byte.
- Flush has priority over rd/wr in the same cycle. It clears pointers, count and the sticky flag of that FIFO only.
- addr_wr_en: i2c_slave_addr <= addr_wr_data on the next edge.
- All outputs are registered, except rd_data (memory read) and flags decoded from count.

Decomposition:
- Package i2c_slave_pkg:
  - localparams I2C_ADDR_W = 7 and I2C_DATA_W = 8;
  - constants TX_EMPTY_BYTE = 8'hFF and RX_EMPTY_BYTE = 8'h00.
- One natural sub-module, i2c_byte_fifo: a parameterised (depth, empty_byte) circular FIFO with count, flags, sticky overflow/underflow and flush.
  - Instantiate it twice.
  - The top level adds the address register and port wiring.

Test Plan:
- Reset: hold rst_n = 0, then release -> i2c_slave_addr = 7'h50; rx_empty = tx_empty = 1; counts = 0; sticky flags = 0.
- Address load: addr_wr_en with 7'h2A -> i2c_slave_addr = 7'h2A next cycle. Assert rst_n = 0 asynchronously -> 7'h50 without waiting for a clock.
- RX order: push 8'hA5, 8'h3C, 8'hFF -> rx_count = 3 and rx_rd_data = A5. Pop three times -> rd_data sequence A5, 3C, FF, then rx_empty = 1 and rx_rd_data = 00.
- TX wrap and full (depth 4):
  - host pushes 01..04 -> tx_full = 1;
  - a fifth push of 05 is dropped;
  - engine pops 2 -> reads 01, 02;
  - host pushes 05, 06 -> following pops yield 03, 04, 05, 06; pointers have wrapped.
- TX underflow: pop on empty -> tx_rd_data = FF, tx_underflow = 1, tx_count = 0. tx_flush -> tx_underflow = 0.
- Simultaneous ops:
  - RX full (depth 4), push 09 and pop together -> rx_count stays 4, head advances, rx_overflow = 0.
  - RX empty, push 07 and pop together -> rx_count = 1 and rx_rd_data = 07 next cycle.
